// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Registered comparison outcome
   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_GT = 2'd1,
      RES_LT = 2'd2
   } res_t;

   // Digit index width; never narrower than one bit, even for a single digit
   function automatic int calc_idxw(input int ndig);
      return (ndig <= 1) ? 1 : $clog2(ndig);
   endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational DIGIT-bit magnitude compare. inv_msb flips the top bit of
// both inputs, turning a two's-complement top digit into offset binary so
// that a plain unsigned compare gives the signed ordering.
module digit_cmp #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             inv_msb,
   output logic             gt,
   output logic             lt
);

   logic [DIGIT-1:0] w_mask;
   logic [DIGIT-1:0] w_x;
   logic [DIGIT-1:0] w_y;

   assign w_mask = DIGIT'(inv_msb) << (DIGIT - 1);
   assign w_x    = x ^ w_mask;
   assign w_y    = y ^ w_mask;

   // Unsigned compare of the adjusted digits
   always_comb begin
      gt = (w_x > w_y);
      lt = (w_x < w_y);
   end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT bits per cycle, MSB digit
// first, in signed or unsigned mode, optionally stopping at the first
// differing digit.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and the result stays stable until out_ready is seen with it.
module seq_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             equal,
   output logic             greater,
   output logic             lesser,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = calc_idxw(NDIG);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("seq_mag_comparator: WIDTH must be a positive multiple of DIGIT");
   end

   state_t            r_state, w_state_nxt;
   logic [IDXW-1:0]   r_idx, w_idx_nxt;
   logic              r_found, w_found_nxt;
   res_t              r_res, w_res_nxt;
   logic [WIDTH-1:0]  r_a, r_b;
   logic              r_signed;
   logic              w_load;
   logic [DIGIT-1:0]  w_da, w_db;
   logic              w_inv_msb;
   logic              w_gt, w_lt, w_diff;

   assign w_da      = r_a[r_idx*DIGIT +: DIGIT];
   assign w_db      = r_b[r_idx*DIGIT +: DIGIT];
   assign w_inv_msb = r_signed && (r_idx == LAST_IDX);
   assign w_diff    = w_gt || w_lt;

   digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
      .x       (w_da),
      .y       (w_db),
      .inv_msb (w_inv_msb),
      .gt      (w_gt),
      .lt      (w_lt)
   );

   // Next-state, index and result update
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_found_nxt = r_found;
      w_res_nxt   = r_res;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_idx_nxt   = LAST_IDX;
               w_found_nxt = 1'b0;
               w_res_nxt   = RES_EQ;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            // Only the most significant difference decides the outcome
            if (!r_found && w_diff) begin
               w_found_nxt = 1'b1;
               w_res_nxt   = w_gt ? RES_GT : RES_LT;
            end
            if (w_diff && (EARLY_EXIT != 0)) begin
               w_state_nxt = DONE;
            end else if (r_idx == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt = r_idx - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
               w_found_nxt = 1'b0;
               w_res_nxt   = RES_EQ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Controller state, digit index and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_found <= 1'b0;
         r_res   <= RES_EQ;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_found <= w_found_nxt;
         r_res   <= w_res_nxt;
      end
   end

   // Operand capture on accept; cleared on reset so stale operands never survive
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
      end else if (w_load) begin
         r_a      <= a;
         r_b      <= b;
         r_signed <= signed_mode;
      end
   end

   // Outputs decode from registered state only; flags are gated by DONE
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      busy      = (r_state != IDLE);
      equal     = out_valid && (r_res == RES_EQ);
      greater   = out_valid && (r_res == RES_GT);
      lesser    = out_valid && (r_res == RES_LT);
      dbg_state = r_state;
   end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three instances (16/4 early exit, 16/4 full
// scan, 4/1 early exit) driven one at a time with directed vectors.
// Expected entries are {inst[1:0], latency[2:0], {eq,gt,lt}}.
module tb_seq_mag_comparator;

   localparam logic [2:0] F_EQ = 3'b100;
   localparam logic [2:0] F_GT = 3'b010;
   localparam logic [2:0] F_LT = 3'b001;

   logic             clk;
   logic             rst;
   logic [2:0]       in_valid, in_ready, sgn, out_valid, out_ready;
   logic [2:0]       equal, greater, lesser, busy;
   logic [2:0][15:0] a_v, b_v;
   logic [2:0][1:0]  dbg;

   logic [7:0] exp_q[$];
   int         n_pass;
   int         n_tot;
   int         ncyc;
   int         acc[3];
   int         lat[3];
   logic [2:0] prev_ov;

   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_v[0]), .b(b_v[0]), .signed_mode(sgn[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .equal(equal[0]), .greater(greater[0]),
      .lesser(lesser[0]), .busy(busy[0]), .dbg_state(dbg[0])
   );

   seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_v[1]), .b(b_v[1]), .signed_mode(sgn[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .equal(equal[1]), .greater(greater[1]),
      .lesser(lesser[1]), .busy(busy[1]), .dbg_state(dbg[1])
   );

   seq_mag_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a_v[2][3:0]), .b(b_v[2][3:0]), .signed_mode(sgn[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .equal(equal[2]), .greater(greater[2]),
      .lesser(lesser[2]), .busy(busy[2]), .dbg_state(dbg[2])
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      n_tot++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
   endtask

   // Present one operand pair to instance i and hold it until accepted
   task automatic issue(input int i, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic [2:0] fl, input logic [2:0] m,
                        input bit push);
      bit ok;
      ok = 1'b0;
      if (push) exp_q.push_back({i[1:0], m, fl});
      @(posedge clk); #1;
      in_valid[i] = 1'b1;
      a_v[i] = av;
      b_v[i] = bv;
      sgn[i] = s;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready[i]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 16'd0, 16'd1);
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      a_v[i] = 16'($urandom_range(0, 16'hFFFF));
      b_v[i] = 16'($urandom_range(0, 16'hFFFF));
      sgn[i] = 1'($urandom_range(0, 1));
   endtask

   // Wait until instance i presents a result
   task automatic wait_out(input int i);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid[i]) return;
      end
      chk("out_timeout", 16'd0, 16'd1);
   endtask

   task automatic chk_idle(input int i, input string nm);
      chk({nm, "_in_ready"}, 16'(in_ready[i]), 16'd1);
      chk({nm, "_out_valid"}, 16'(out_valid[i]), 16'd0);
      chk({nm, "_flags"}, 16'({equal[i], greater[i], lesser[i]}), 16'd0);
      chk({nm, "_busy"}, 16'(busy[i]), 16'd0);
   endtask

   // Monitor: latency measurement, output-handshake scoreboard, flag invariant
   always @(negedge clk) begin
      logic [7:0] e;
      ncyc = ncyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            if (in_valid[i] && in_ready[i]) acc[i] = ncyc;
            if (out_valid[i] && !prev_ov[i]) lat[i] = ncyc - acc[i] - 1;
            if (out_valid[i]) chk("onehot", 16'($countones({equal[i], greater[i], lesser[i]})), 16'd1);
            else chk("flags_idle", 16'({equal[i], greater[i], lesser[i]}), 16'd0);
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected", 16'(i), 16'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_inst", 16'(i), 16'(e[7:6]));
                  chk("sb_flags", 16'({equal[i], greater[i], lesser[i]}), 16'(e[2:0]));
                  chk("sb_latency", 16'(lat[i]), 16'(e[5:3]));
               end
            end
         end
         prev_ov[i] = out_valid[i];
      end
   end

   // Directed stimulus
   initial begin
      bit ok;
      n_pass = 0; n_tot = 0; ncyc = 0; prev_ov = '0;
      for (int i = 0; i < 3; i++) begin acc[i] = 0; lat[i] = 0; end
      rst = 1'b1; in_valid = '0; sgn = '0; out_ready = 3'b111; a_v = '0; b_v = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle(0, "reset0");
      chk_idle(1, "reset1");
      chk_idle(2, "reset2");

      // Equal operands scan every digit; IDLE right after the handshake
      issue(0, 16'h1234, 16'h1234, 1'b0, F_EQ, 3'd4, 1'b1);
      wait_out(0);
      @(negedge clk);
      chk("eq_in_ready_after", 16'(in_ready[0]), 16'd1);
      chk("eq_out_valid_after", 16'(out_valid[0]), 16'd0);

      // Top digit decides, unsigned vs signed
      issue(0, 16'h8000, 16'h7FFF, 1'b0, F_GT, 3'd1, 1'b1);
      wait_out(0);
      issue(0, 16'h8000, 16'h7FFF, 1'b1, F_LT, 3'd1, 1'b1);
      wait_out(0);

      // Difference only in the last digit
      issue(0, 16'h0035, 16'h0037, 1'b0, F_LT, 3'd4, 1'b1);
      wait_out(0);

      // Full scan instance: first difference wins, later digits ignored
      issue(1, 16'hF000, 16'h0000, 1'b0, F_GT, 3'd4, 1'b1);
      wait_out(1);
      issue(1, 16'h1F00, 16'h2000, 1'b0, F_LT, 3'd4, 1'b1);
      wait_out(1);
      issue(1, 16'hFFFF, 16'h0001, 1'b1, F_LT, 3'd4, 1'b1);
      wait_out(1);

      // Backpressure: result held, inputs ignored
      out_ready[0] = 1'b0;
      issue(0, 16'h5000, 16'h4FFF, 1'b0, F_GT, 3'd1, 1'b1);
      wait_out(0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         in_valid[0] = ~in_valid[0];
         a_v[0] = 16'($urandom_range(0, 16'hFFFF));
         b_v[0] = 16'($urandom_range(0, 16'hFFFF));
         @(negedge clk);
         chk("bp_out_valid", 16'(out_valid[0]), 16'd1);
         chk("bp_flags", 16'({equal[0], greater[0], lesser[0]}), 16'(F_GT));
         chk("bp_in_ready", 16'(in_ready[0]), 16'd0);
         chk("bp_busy", 16'(busy[0]), 16'd1);
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_idle(0, "bp_release");
      repeat (3) @(negedge clk);
      chk("bp_no_extra", 16'(out_valid[0]), 16'd0);

      // Reset during the second RUN cycle abandons the operation
      issue(0, 16'h0010, 16'h0020, 1'b0, F_LT, 3'd3, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle(0, "mid_reset");
      repeat (4) @(negedge clk);
      chk("mid_reset_no_out", 16'(out_valid[0]), 16'd0);
      issue(0, 16'h0001, 16'h0002, 1'b0, F_LT, 3'd4, 1'b1);
      wait_out(0);

      // Single-bit digits on a 4-bit instance
      issue(2, 16'h0000, 16'h0000, 1'b0, F_EQ, 3'd4, 1'b1);
      wait_out(2);
      issue(2, 16'h0003, 16'h0007, 1'b0, F_LT, 3'd2, 1'b1);
      wait_out(2);
      issue(2, 16'h000E, 16'h000C, 1'b0, F_GT, 3'd3, 1'b1);
      wait_out(2);
      issue(2, 16'h0008, 16'h0001, 1'b1, F_LT, 3'd1, 1'b1);
      wait_out(2);

      // Drain the scoreboard
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("sb_drained", 16'(ok), 16'd1);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
